// File: rtl/avm_sample_logger_master.sv
`default_nettype none
// ============================================================================
// Module      : avm_sample_logger_master
// Description : Avalon-MM write master that stores a valid/ready sample stream
//               into a circular word buffer. Tracks write pointer, saturating
//               fill count and a sticky wrap flag for the reading software.
// Revision    : 1.0 - initial release
// ============================================================================
module avm_sample_logger_master #(
  parameter int ADDR_W      = 15,
  parameter int BASE_WORD   = 0,
  parameter int DEPTH_WORDS = 30000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [31:0]       snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [CNT_W-1:0]  word_count,
  output logic              wrap_flag,
  output logic              busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W-1:0] c_one_a = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  c_depth = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  c_one_c = CNT_W'(1);

  logic [0:0]  r_state;
  logic [31:0] r_hold;
  logic        r_hold_valid;
  logic        r_clear_pend;

  logic w_accept;
  logic w_done;
  logic w_clear_on_done;

  // Input handshake: one-word holding register, closed while clear is pulsed
  assign snk_ready       = enable & ~r_hold_valid & ~clear;
  assign w_accept        = snk_valid & snk_ready;
  // Bus transfer finishes in any WRITE cycle without a stall
  assign w_done          = (r_state == S_WRITE) & ~avm_waitrequest;
  // A clear seen during the write (latched or on the final cycle) wins over the update
  assign w_clear_on_done = r_clear_pend | clear;

  assign avm_byteenable  = 4'hF;
  assign busy            = r_hold_valid | (r_state == S_WRITE);

  // Holding register, write FSM and buffer bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_hold         <= 32'h0;
      r_hold_valid   <= 1'b0;
      r_clear_pend   <= 1'b0;
      avm_address    <= '0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= 32'h0;
      wr_ptr         <= '0;
      word_count     <= '0;
      wrap_flag      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold       <= snk_data;
        r_hold_valid <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (clear) begin
            // Empty the buffer state and drop any word not yet on the bus
            wr_ptr       <= '0;
            word_count   <= '0;
            wrap_flag    <= 1'b0;
            r_hold_valid <= 1'b0;
          end else if (r_hold_valid) begin
            avm_write      <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_address    <= c_base + wr_ptr;
            avm_writedata  <= r_hold;
            r_state        <= S_WRITE;
          end
        end

        S_WRITE: begin
          // The request is never withdrawn; a clear only takes effect at completion
          if (clear) begin
            r_clear_pend <= 1'b1;
          end
          if (w_done) begin
            avm_write      <= 1'b0;
            avm_chipselect <= 1'b0;
            r_hold_valid   <= 1'b0;
            r_clear_pend   <= 1'b0;
            r_state        <= S_IDLE;
            if (w_clear_on_done) begin
              wr_ptr     <= '0;
              word_count <= '0;
              wrap_flag  <= 1'b0;
            end else begin
              if (wr_ptr == c_last) begin
                wr_ptr    <= '0;
                wrap_flag <= 1'b1;
              end else begin
                wr_ptr <= wr_ptr + c_one_a;
              end
              if (word_count < c_depth) begin
                word_count <= word_count + c_one_c;
              end
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avm_sample_logger_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_avm_sample_logger_master
// Description : Directed, table-driven bench. Two instances share stimulus:
//               "a" uses default parameters, "b" a 4-word buffer at word 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avm_sample_logger_master;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        waitreq;

  logic        a_ready, a_cs, a_write, a_wrap, a_busy;
  logic [14:0] a_addr, a_ptr;
  logic [15:0] a_cnt;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;

  logic        b_ready, b_cs, b_write, b_wrap, b_busy;
  logic [4:0]  b_addr, b_ptr;
  logic [2:0]  b_cnt;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;

  int n_checks = 0;
  int n_errors = 0;

  avm_sample_logger_master dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(a_ready),
    .avm_address(a_addr), .avm_chipselect(a_cs), .avm_write(a_write),
    .avm_writedata(a_wdata), .avm_byteenable(a_be), .avm_waitrequest(waitreq),
    .wr_ptr(a_ptr), .word_count(a_cnt), .wrap_flag(a_wrap), .busy(a_busy)
  );

  avm_sample_logger_master #(
    .ADDR_W(5), .BASE_WORD(16), .DEPTH_WORDS(4), .CNT_W(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(b_ready),
    .avm_address(b_addr), .avm_chipselect(b_cs), .avm_write(b_write),
    .avm_writedata(b_wdata), .avm_byteenable(b_be), .avm_waitrequest(waitreq),
    .wr_ptr(b_ptr), .word_count(b_cnt), .wrap_flag(b_wrap), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] data;
    int nwait;
    int clear_at;
    int a_addr;
    int a_ptr;
    int a_cnt;
    int b_addr;
    int b_ptr;
    int b_cnt;
    int b_wrap;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One sample through the whole write path, checked cycle by cycle
  task automatic write_word(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    enable = 1'b1; snk_valid = 1'b1; snk_data = v.data;
    #1 chk({t, " snk_ready_before"}, a_ready, 1);
    @(negedge clk);                      // accepted on previous edge
    snk_valid = 1'b0; snk_data = 32'h0;
    chk({t, " write_n+1"}, a_write, 0);
    chk({t, " busy_n+1"}, a_busy, 1);
    @(negedge clk);                      // N+2: request on the bus
    waitreq = (v.nwait > 0);
    chk({t, " write_n+2"}, a_write, 1);
    chk({t, " cs_n+2"}, a_cs, 1);
    chk({t, " be"}, a_be, 32'hF);
    chk({t, " addr_a"}, a_addr, v.a_addr);
    chk({t, " addr_b"}, b_addr, v.b_addr);
    chk({t, " wdata"}, a_wdata, v.data);
    for (int i = 0; i < v.nwait; i++) begin
      if (i == v.clear_at) clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      waitreq = (i + 1 < v.nwait);
      chk({t, " stall_write"}, a_write, 1);
      chk({t, " stall_addr"}, a_addr, v.a_addr);
      chk({t, " stall_wdata"}, a_wdata, v.data);
      chk({t, " stall_ready"}, a_ready, 0);
    end
    @(negedge clk);                      // completion visible
    chk({t, " write_done"}, a_write, 0);
    chk({t, " cs_done"}, a_cs, 0);
    chk({t, " busy_done"}, a_busy, 0);
    chk({t, " ready_done"}, a_ready, 1);
    chk({t, " ptr_a"}, a_ptr, v.a_ptr);
    chk({t, " cnt_a"}, a_cnt, v.a_cnt);
    chk({t, " wrap_a"}, a_wrap, 0);
    chk({t, " ptr_b"}, b_ptr, v.b_ptr);
    chk({t, " cnt_b"}, b_cnt, v.b_cnt);
    chk({t, " wrap_b"}, b_wrap, v.b_wrap);
  endtask

  initial begin
    //        data          nw clr a_ad a_pt a_cn b_ad b_pt b_cn b_wr
    vecs[0] = '{32'hA5A50001, 0, -1, 0,   1,   1,   16,  1,   1,   0};
    vecs[1] = '{32'h00000002, 1, -1, 1,   2,   2,   17,  2,   2,   0};
    vecs[2] = '{32'hDEADBEEF, 0, -1, 2,   3,   3,   18,  3,   3,   0};
    vecs[3] = '{32'h0000FFFF, 2, -1, 3,   4,   4,   19,  0,   4,   1};
    vecs[4] = '{32'hFFFF0000, 0, -1, 4,   5,   5,   16,  1,   4,   1};
    vecs[5] = '{32'h80000001, 0, -1, 5,   6,   6,   17,  2,   4,   1};
    vecs[6] = '{32'h13579BDF, 0, -1, 6,   7,   7,   18,  3,   4,   1};
    vecs[7] = '{32'h12345678, 5, -1, 7,   8,   8,   19,  0,   4,   1};
    // clear pulsed in the first stall cycle: write completes, then all zero
    vecs[8] = '{32'hCAFE0001, 3,  0, 8,   0,   0,   16,  0,   0,   0};

    reset_n = 1'b0; enable = 1'b0; clear = 1'b0;
    snk_data = 32'h0; snk_valid = 1'b0; waitreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst write", a_write, 0);
    chk("rst cs", a_cs, 0);
    chk("rst ptr", a_ptr, 0);
    chk("rst cnt", a_cnt, 0);
    chk("rst wrap", a_wrap, 0);
    chk("rst busy", a_busy, 0);
    chk("rst ready", a_ready, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 9; k++) write_word(vecs[k], k);

    // No write follows the cleared transfer
    repeat (3) begin
      @(negedge clk);
      chk("post_clear write_a", a_write, 0);
      chk("post_clear write_b", b_write, 0);
    end

    // Clear in IDLE discards a held word
    write_word('{32'h11111111, 0, -1, 0, 1, 1, 16, 1, 1, 0}, 9);
    @(negedge clk);
    snk_valid = 1'b1; snk_data = 32'h22222222;
    @(negedge clk);
    snk_valid = 1'b0; clear = 1'b1;
    #1 chk("idle_clear ready", a_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    chk("idle_clear write", a_write, 0);
    chk("idle_clear busy", a_busy, 0);
    chk("idle_clear ptr", a_ptr, 0);
    chk("idle_clear cnt", a_cnt, 0);
    @(negedge clk);
    chk("idle_clear write2", a_write, 0);

    // Clear coincident with valid: nothing accepted
    snk_valid = 1'b1; snk_data = 32'h33333333; clear = 1'b1;
    #1 chk("clear_accept ready", a_ready, 0);
    @(negedge clk);
    clear = 1'b0; snk_valid = 1'b0;
    chk("clear_accept busy", a_busy, 0);

    // Enable dropped the cycle after an accept
    @(negedge clk);
    enable = 1'b1; snk_valid = 1'b1; snk_data = 32'h0BADF00D;
    @(negedge clk);
    enable = 1'b0; snk_data = 32'h99999999;
    #1 chk("en_drop ready_n+1", a_ready, 0);
    @(negedge clk);
    chk("en_drop write", a_write, 1);
    chk("en_drop wdata", a_wdata, 32'h0BADF00D);
    chk("en_drop addr", a_addr, 0);
    @(negedge clk);
    chk("en_drop write_done", a_write, 0);
    chk("en_drop cnt", a_cnt, 1);
    chk("en_drop ptr", a_ptr, 1);
    repeat (4) begin
      @(negedge clk);
      chk("en_drop idle_ready", a_ready, 0);
      chk("en_drop idle_write", a_write, 0);
    end
    snk_valid = 1'b0;
    chk("en_drop cnt_final", a_cnt, 1);
    chk("en_drop busy_final", a_busy, 0);

    // Asynchronous reset in the middle of a stalled write
    @(negedge clk);
    enable = 1'b1; snk_valid = 1'b1; snk_data = 32'h55AA55AA;
    @(negedge clk);
    snk_valid = 1'b0;
    @(negedge clk);
    waitreq = 1'b1;
    chk("mid_rst write_before", a_write, 1);
    chk("mid_rst addr_before", a_addr, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst write", a_write, 0);
    chk("mid_rst cs", a_cs, 0);
    chk("mid_rst addr", a_addr, 0);
    chk("mid_rst ptr", a_ptr, 0);
    chk("mid_rst cnt", a_cnt, 0);
    chk("mid_rst busy", a_busy, 0);
    @(negedge clk);
    reset_n = 1'b1; waitreq = 1'b0;
    write_word('{32'h0F0F0F0F, 0, -1, 0, 1, 1, 16, 1, 1, 0}, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avm_sample_logger_master.md
Name: avm_sample_logger_master

Overview:
- Avalon-MM write master that takes a 32-bit sample stream (valid/ready) and stores each sample as one word in the on-chip memory slave.
- The memory region is a circular buffer. The block tracks a write pointer, a saturating fill count and a sticky wrap flag for the Nios software that later reads the buffer.
- Sits between the power-monitor sample source and the Qsys interconnect, on the same clock as the memory.

Parameters:
- ADDR_W, 15, width of avm_address (word address, matches memory widthad).
- BASE_WORD, 0, first word address of the buffer region.
- DEPTH_WORDS, 30000, number of words in the buffer; legal range 2..2^ADDR_W-BASE_WORD.
- CNT_W, 16, width of word_count; must hold DEPTH_WORDS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = accept samples; 0 = stop accepting (in-flight work completes).
- clear  in  1  single-cycle pulse: empty the buffer state.
- snk_data  in  32  sample word.
- snk_valid  in  1  sample present.
- snk_ready  out  1  block can accept a sample this cycle.
- avm_address  out  ADDR_W  word address = BASE_WORD + wr_ptr.
- avm_chipselect  out  1  asserted together with avm_write.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_waitrequest  in  1  interconnect stall.
- wr_ptr  out  ADDR_W  next buffer offset to be written (0..DEPTH_WORDS-1).
- word_count  out  CNT_W  words written, saturates at DEPTH_WORDS.
- wrap_flag  out  1  sticky: pointer has wrapped at least once.
- busy  out  1  hold_valid OR state==WRITE.

Behaviour:
Reset (async, reset_n=0):
- All registered outputs are 0: avm_write, avm_chipselect, wr_ptr, word_count, wrap_flag, busy.
- hold_valid=0, state=IDLE, snk_ready=0.

Input side:
- One-word holding register.
- snk_ready = enable & ~hold_valid & ~clear (combinational).
- Accept when snk_valid & snk_ready: hold<=snk_data, hold_valid<=1.

FSM, two states:
- IDLE: if hold_valid, register avm_write=1, avm_chipselect=1, avm_address=BASE_WORD+wr_ptr, avm_writedata=hold; go to WRITE.
- WRITE, while avm_waitrequest=1: address, data, write and chipselect are held stable. The write is never withdrawn, regardless of enable, clear or snk_*.
- WRITE, on avm_waitrequest=0 (transfer completes this cycle). Next cycle:
  - avm_write=0, avm_chipselect=0, hold_valid=0, state=IDLE.
  - wr_ptr <= (wr_ptr==DEPTH_WORDS-1) ? 0 : wr_ptr+1; wrap_flag set on that wrap.
  - word_count <= min(word_count+1, DEPTH_WORDS).

Timing:
- Sample accepted at cycle N; avm_write high at N+2.
- With waitrequest=0 at N+2: wr_ptr updated and snk_ready high at N+3.
- Sustained throughput is 1 word per 3 cycles, plus any waitrequest cycles.

Clear:
- In IDLE: wr_ptr=0, word_count=0, wrap_flag=0, held word discarded (hold_valid=0), all next cycle.
- In WRITE: clear is latched as pending. The in-flight write completes normally on the bus. On completion the normal pointer/count update is replaced by the clear (all three = 0, hold_valid=0).
- clear coincident with an accept: no accept (snk_ready is 0).

Enable:
- Deassert stops new accepts only. An already-held word is still written.

Old data:
- Never read back. Buffer contents older than DEPTH_WORDS writes are overwritten.

Test Plan:
- Reset, enable=1, waitrequest=0, send 0xA5A50001 -> avm_write high exactly 2 cycles after accept, address 0, byteenable F; after completion wr_ptr=1, word_count=1, busy=0.
- Hold waitrequest=1 for 5 cycles during a write of 0x12345678 at address 7 -> address, data and write stable for all 6 cycles; snk_ready=0 throughout; one pointer increment only.
- DEPTH_WORDS=4, BASE_WORD=16, write 6 samples -> addresses 16,17,18,19,16,17; wrap_flag=1 after the 4th; word_count saturates at 4; final wr_ptr=2.
- clear pulsed during a stalled write (waitrequest=1 for 3 cycles) -> write completes with original data; then wr_ptr=0, word_count=0, wrap_flag=0, no further write.
- enable dropped the cycle after an accept -> held word still written once; subsequent snk_valid ignored (snk_ready=0); word_count increments by exactly 1.
- reset_n asserted mid-write (avm_write=1, waitrequest=1) -> all outputs 0 immediately (asynchronous); after release, block is idle and accepts a new sample at address BASE_WORD.
